// File: rtl/pipes.sv
// Shared encodings for the execute-stage operand unit: operand selects, word modes, constants.
package pipes;

    typedef enum logic [1:0] {
        SELA_RS1  = 2'd0,
        SELA_PC   = 2'd1,
        SELA_ZERO = 2'd2
    } sela_t;

    typedef enum logic [1:0] {
        SELB_RS2  = 2'd0,
        SELB_IMM  = 2'd1,
        SELB_FOUR = 2'd2,
        SELB_ZERO = 2'd3
    } selb_t;

    typedef enum logic [1:0] {
        WM_FULL   = 2'd0,
        WM_SEXT32 = 2'd1,
        WM_ZEXT32 = 2'd2
    } wmode_t;

    localparam int unsigned OP_FOUR = 4;

endpackage

// File: rtl/operand_bypass.sv
// Forwarding mux for one source operand: youngest matching bypass wins, x0 reads zero.
// Purely combinational, 0 cycles; pending flags a load-use stall for the winning source.
module operand_bypass #(
    parameter int XLEN = 64,
    parameter int NBYP = 2,
    parameter int RAW  = 5
) (
    input  logic [RAW-1:0]       addr,
    input  logic [XLEN-1:0]      rf_data,
    input  logic [NBYP-1:0]      byp_valid,
    input  logic [NBYP*RAW-1:0]  byp_rd,
    input  logic [NBYP*XLEN-1:0] byp_data,
    input  logic [NBYP-1:0]      byp_pending,
    output logic [XLEN-1:0]      data,
    output logic                 pending
);

    logic hit;

    // Only the first (youngest) match counts; an older ready copy never hides a pending one.
    always_comb begin
        hit     = 1'b0;
        data    = rf_data;
        pending = 1'b0;
        for (int i = 0; i < NBYP; i++) begin
            if (!hit && byp_valid[i] && byp_rd[i*RAW +: RAW] == addr) begin
                hit     = 1'b1;
                data    = byp_data[i*XLEN +: XLEN];
                pending = byp_pending[i];
            end
        end
        if (addr == '0) begin
            data    = '0;
            pending = 1'b0;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Execute-stage operand forward/select into a one-entry register; 1-cycle accept-to-valid latency.
// Backpressure: in_ready drops on flush, load-use hazard, or a held result the ALU has not taken.
module alu_operand_stage
    import pipes::*;
#(
    parameter int XLEN = 64,
    parameter int NBYP = 2,
    parameter int RAW  = 5,
    parameter int CW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [RAW-1:0]       in_rs1,
    input  logic [RAW-1:0]       in_rs2,
    input  logic [XLEN-1:0]      in_rf_a,
    input  logic [XLEN-1:0]      in_rf_b,
    input  logic [1:0]           in_sela,
    input  logic [1:0]           in_selb,
    input  logic [1:0]           in_wmode,
    input  logic                 in_store,
    input  logic [NBYP-1:0]      byp_valid,
    input  logic [NBYP*RAW-1:0]  byp_rd,
    input  logic [NBYP*XLEN-1:0] byp_data,
    input  logic [NBYP-1:0]      byp_pending,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [XLEN-1:0]      store_data,
    output logic [CW-1:0]        hazard_cycles
);

    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            rs1_pend, rs2_pend;
    logic            rs1_used, rs2_used;
    logic            hazard;
    logic [XLEN-1:0] a_sel, b_sel, a_nxt, b_nxt;

    function automatic logic [XLEN-1:0] word_mode(input logic [1:0] wm, input logic [XLEN-1:0] x);
        case (wm)
            WM_SEXT32: return {{(XLEN-32){x[31]}}, x[31:0]};
            WM_ZEXT32: return {{(XLEN-32){1'b0}}, x[31:0]};
            default:   return x;
        endcase
    endfunction

    operand_bypass #(.XLEN(XLEN), .NBYP(NBYP), .RAW(RAW)) u_byp_rs1 (
        .addr        (in_rs1),
        .rf_data     (in_rf_a),
        .byp_valid   (byp_valid),
        .byp_rd      (byp_rd),
        .byp_data    (byp_data),
        .byp_pending (byp_pending),
        .data        (rs1_val),
        .pending     (rs1_pend)
    );

    operand_bypass #(.XLEN(XLEN), .NBYP(NBYP), .RAW(RAW)) u_byp_rs2 (
        .addr        (in_rs2),
        .rf_data     (in_rf_b),
        .byp_valid   (byp_valid),
        .byp_rd      (byp_rd),
        .byp_data    (byp_data),
        .byp_pending (byp_pending),
        .data        (rs2_val),
        .pending     (rs2_pend)
    );

    always_comb begin
        case (in_sela)
            SELA_PC:   a_sel = in_pc;
            SELA_ZERO: a_sel = '0;
            default:   a_sel = rs1_val;
        endcase
        case (in_selb)
            SELB_IMM:  b_sel = in_imm;
            SELB_FOUR: b_sel = XLEN'(OP_FOUR);
            SELB_ZERO: b_sel = '0;
            default:   b_sel = rs2_val;
        endcase
        a_nxt = word_mode(in_wmode, a_sel);
        b_nxt = word_mode(in_wmode, b_sel);
    end

    // in_ready must not depend on in_valid, so the stall term here is ungated;
    // the stall counter applies the in_valid qualification.
    assign rs1_used = (in_sela == SELA_RS1) || (in_sela == 2'd3);
    assign rs2_used = (in_selb == SELB_RS2) || in_store;
    assign hazard   = (rs1_used && rs1_pend) || (rs2_used && rs2_pend);
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            store_data    <= '0;
            hazard_cycles <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (in_valid && in_ready) begin
                out_valid  <= 1'b1;
                alu_a      <= a_nxt;
                alu_b      <= b_nxt;
                store_data <= rs2_val;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_valid && hazard && !flush && hazard_cycles != {CW{1'b1}}) begin
                hazard_cycles <= hazard_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and randomized bench for alu_operand_stage against a behavioural operand model.
module tb_alu_operand_stage;

    localparam int XLEN = 64;
    localparam int NBYP = 2;
    localparam int RAW  = 5;
    localparam int CW   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, flush, in_valid, in_ready, in_store, out_valid, out_ready;
    logic [XLEN-1:0]      in_pc, in_imm, in_rf_a, in_rf_b, alu_a, alu_b, store_data;
    logic [RAW-1:0]       in_rs1, in_rs2;
    logic [1:0]           in_sela, in_selb, in_wmode;
    logic [NBYP-1:0]      byp_valid, byp_pending;
    logic [RAW-1:0]       b_rd  [NBYP];
    logic [XLEN-1:0]      b_dat [NBYP];
    logic [NBYP*RAW-1:0]  byp_rd;
    logic [NBYP*XLEN-1:0] byp_data;
    logic [CW-1:0]        hazard_cycles;

    assign byp_rd   = {b_rd[1], b_rd[0]};
    assign byp_data = {b_dat[1], b_dat[0]};

    alu_operand_stage #(.XLEN(XLEN), .NBYP(NBYP), .RAW(RAW), .CW(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_imm        (in_imm),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rf_a       (in_rf_a),
        .in_rf_b       (in_rf_b),
        .in_sela       (in_sela),
        .in_selb       (in_selb),
        .in_wmode      (in_wmode),
        .in_store      (in_store),
        .byp_valid     (byp_valid),
        .byp_rd        (byp_rd),
        .byp_data      (byp_data),
        .byp_pending   (byp_pending),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .store_data    (store_data),
        .hazard_cycles (hazard_cycles)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: what the output register and counter should hold.
    logic        m_v;
    logic [63:0] m_a, m_b, m_sd;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [63:0] fwd(input logic [4:0] addr, input logic [63:0] rf, output logic pend);
        pend = 1'b0;
        if (addr == 5'd0) return 64'd0;
        for (int i = 0; i < NBYP; i++) begin
            if (byp_valid[i] && b_rd[i] == addr) begin
                pend = byp_pending[i];
                return b_dat[i];
            end
        end
        return rf;
    endfunction

    function automatic logic [63:0] wm(input logic [1:0] m, input logic [63:0] x);
        if (m == 2'd1) return x[31] ? (x | 64'hFFFF_FFFF_0000_0000) : (x & 64'h0000_0000_FFFF_FFFF);
        if (m == 2'd2) return x & 64'h0000_0000_FFFF_FFFF;
        return x;
    endfunction

    // One clock: check in_ready, advance the model, check the registered outputs.
    task automatic cycle();
        logic [63:0] v1, v2, a, b;
        logic        p1, p2, haz, rdy;
        #1;
        v1  = fwd(in_rs1, in_rf_a, p1);
        v2  = fwd(in_rs2, in_rf_b, p2);
        a   = (in_sela == 2'd1) ? in_pc : (in_sela == 2'd2) ? 64'd0 : v1;
        case (in_selb)
            2'd0:    b = v2;
            2'd1:    b = in_imm;
            2'd2:    b = 64'd4;
            default: b = 64'd0;
        endcase
        haz = (p1 && (in_sela == 2'd0 || in_sela == 2'd3)) || (p2 && (in_selb == 2'd0 || in_store));
        rdy = !flush && !haz && (!m_v || out_ready);
        if (reset) chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
        if (!reset) begin
            m_v = 1'b0; m_a = '0; m_b = '0; m_sd = '0; m_cnt = '0;
        end else begin
            if (in_valid && haz && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (flush) m_v = 1'b0;
            else if (in_valid && rdy) begin
                m_v  = 1'b1;
                m_a  = wm(in_wmode, a);
                m_b  = wm(in_wmode, b);
                m_sd = v2;
            end else if (out_ready) m_v = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_v});
        if (m_v) begin
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("store_data", store_data, m_sd);
        end
        chk("hazard_cycles", {32'd0, hazard_cycles}, {32'd0, m_cnt});
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; out_ready = 1; in_store = 0;
        in_pc = 0; in_imm = 0; in_rf_a = 0; in_rf_b = 0;
        in_rs1 = 0; in_rs2 = 0; in_sela = 0; in_selb = 0; in_wmode = 0;
        byp_valid = 0; byp_pending = 0;
        for (int i = 0; i < NBYP; i++) begin b_rd[i] = 0; b_dat[i] = 0; end
    endtask

    task automatic rand_inputs();
        flush     = ($urandom_range(0, 9) == 0);
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        in_store  = $urandom_range(0, 1) == 1;
        in_pc     = {$urandom, $urandom};
        in_imm    = {$urandom, $urandom};
        in_rf_a   = {$urandom, $urandom};
        in_rf_b   = {$urandom, $urandom};
        in_rs1    = 5'($urandom_range(0, 3));
        in_rs2    = 5'($urandom_range(0, 3));
        in_sela   = 2'($urandom_range(0, 3));
        in_selb   = 2'($urandom_range(0, 3));
        in_wmode  = 2'($urandom_range(0, 3));
        for (int i = 0; i < NBYP; i++) begin
            byp_valid[i]   = $urandom_range(0, 1) == 1;
            byp_pending[i] = ($urandom_range(0, 3) == 0);
            b_rd[i]        = 5'($urandom_range(0, 3));
            b_dat[i]       = {$urandom, $urandom};
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout n_chk=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        m_v = 0; m_a = 0; m_b = 0; m_sd = 0; m_cnt = 0;
        reset = 0;
        rand_inputs();
        cycle();
        rand_inputs();
        cycle();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_a", alu_a, 64'd0);
        chk("rst_b", alu_b, 64'd0);
        chk("rst_sd", store_data, 64'd0);
        chk("rst_cnt", {32'd0, hazard_cycles}, 64'd0);

        // Forwarding priority and x0
        reset = 1;
        idle();
        in_valid = 1; in_rs1 = 5; in_rf_a = 64'h10;
        byp_valid = 2'b11; b_rd[0] = 5; b_dat[0] = 64'hAA; b_rd[1] = 5; b_dat[1] = 64'hBB;
        cycle();
        chk("fwd_prio", alu_a, 64'hAA);
        in_rs1 = 0; b_rd[0] = 0; b_dat[0] = 64'hCC; in_rf_a = 64'h77;
        cycle();
        chk("fwd_x0", alu_a, 64'd0);

        // Selection and word modes
        idle();
        in_valid = 1; in_sela = 1; in_pc = 64'h8000_0000; in_selb = 2;
        cycle();
        chk("sel_pc", alu_a, 64'h8000_0000);
        chk("sel_four", alu_b, 64'd4);
        in_sela = 0; in_rs1 = 5; in_rf_a = 64'h0000_0000_8000_0001; in_wmode = 1;
        cycle();
        chk("sext32", alu_a, 64'hFFFF_FFFF_8000_0001);
        in_wmode = 2;
        cycle();
        chk("zext32", alu_a, 64'h0000_0000_8000_0001);

        // Load-use stall
        idle();
        in_valid = 1; in_sela = 1; in_rs2 = 7; in_selb = 0;
        byp_valid = 2'b01; b_rd[0] = 7; byp_pending = 2'b01;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("lu_stall", {63'd0, in_ready}, 64'd0);
        end
        chk("lu_cnt", {32'd0, hazard_cycles}, 64'd3);
        byp_pending = 0; b_dat[0] = 64'h55;
        cycle();
        chk("lu_data", alu_b, 64'h55);
        in_selb = 1; in_imm = 64'h1234; byp_pending = 2'b01;
        cycle();
        chk("no_stall_v", {63'd0, out_valid}, 64'd1);
        chk("no_stall_cnt", {32'd0, hazard_cycles}, 64'd3);

        // Backpressure then a back-to-back stream
        idle();
        in_valid = 1; in_sela = 1; in_pc = 64'h100;
        cycle();
        out_ready = 0; in_pc = 64'h200;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("bp_hold", alu_a, 64'h100);
            chk("bp_rdy", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            in_pc = 64'h300 + 64'(i);
            cycle();
            chk("stream_v", {63'd0, out_valid}, 64'd1);
            chk("stream_a", alu_a, 64'h300 + 64'(i));
        end

        // Flush with a held result and a new op present
        out_ready = 0; flush = 1; in_pc = 64'h500;
        cycle();
        chk("flush_v", {63'd0, out_valid}, 64'd0);
        flush = 0; out_ready = 1; in_pc = 64'h400;
        cycle();
        chk("post_flush_v", {63'd0, out_valid}, 64'd1);
        chk("post_flush_a", alu_a, 64'h400);

        // Random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            reset = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
